theremin_period_meter: RTL and testbench



---
 rtl/theremin_period_meter.sv | 175 +++++++++++++++++
 tb/tb_theremin_period_meter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/theremin_period_meter.sv
// Measures the antenna oscillator period in clk_clk cycles and publishes a block average
// over a valid/ready handshake. Define THEREMIN_PERIOD_METER_IIR_EN for exponential smoothing.
module theremin_period_meter #(
    parameter int unsigned      CNT_W      = 20,
    parameter int unsigned      AVG_LOG2   = 2,
    parameter int unsigned      MIN_PERIOD = 16,
    parameter logic [CNT_W-1:0] TIMEOUT    = {CNT_W{1'b1}}
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic             osc_in,
    output logic [CNT_W-1:0] period_data,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             no_signal,
    output logic             overrun
);
    localparam int unsigned      ACC_W = CNT_W + AVG_LOG2;
    localparam int unsigned      N     = 1 << AVG_LOG2;
    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);

    typedef enum logic [0:0] {StIdle, StArmed} state_e;

    state_e           state_q, state_d;
    logic             sync1_q, sync2_q, edge_q;
    logic             rise, timeout;
    logic [CNT_W-1:0] cnt_q, cnt_d, p;
    logic             no_signal_q, no_signal_d;
    logic             valid_q, valid_d, overrun_q, overrun_d;
    logic [CNT_W-1:0] data_q, data_d;
    logic             res_load;
    logic [CNT_W-1:0] res_data;

`ifdef THEREMIN_PERIOD_METER_IIR_EN
    logic [ACC_W-1:0]  y_q, y_d, p_ext, y_next;
    logic              y_init_q, y_init_d;
    logic signed [ACC_W:0] diff, step;

    // y keeps AVG_LOG2 fractional bits so the smoothing step does not lose resolution
    assign p_ext  = ACC_W'(p) << AVG_LOG2;
    assign diff   = $signed({1'b0, p_ext}) - $signed({1'b0, y_q});
    assign step   = diff >>> AVG_LOG2;
    assign y_next = y_q + step[ACC_W-1:0];
`else
    localparam logic [4:0] K_LAST = 5'(N - 1);
    logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic [4:0]       k_q, k_d;

    assign acc_sum = acc_q + ACC_W'(p);
`endif

    assign rise    = sync2_q & ~edge_q;
    assign p       = cnt_q + CNT_W'(1);
    assign timeout = (state_q == StArmed) && (cnt_q == TIMEOUT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == TIMEOUT) ? cnt_q : cnt_q + CNT_W'(1);
        no_signal_d = no_signal_q;
        res_load    = 1'b0;
        res_data    = '0;
`ifdef THEREMIN_PERIOD_METER_IIR_EN
        y_d         = y_q;
        y_init_d    = y_init_q;
`else
        acc_d       = acc_q;
        k_d         = k_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StArmed;
                    cnt_d   = '0;
`ifdef THEREMIN_PERIOD_METER_IIR_EN
                    y_init_d = 1'b0;
`else
                    acc_d    = '0;
                    k_d      = '0;
`endif
                end
            end
            StArmed: begin
                // Timeout wins over a coincident rise
                if (timeout) begin
                    state_d     = StIdle;
                    no_signal_d = 1'b1;
`ifdef THEREMIN_PERIOD_METER_IIR_EN
                    y_d      = '0;
                    y_init_d = 1'b0;
`else
                    acc_d    = '0;
                    k_d      = '0;
`endif
                end else if (rise && (p >= MIN_P)) begin
                    cnt_d       = '0;
                    no_signal_d = 1'b0;
                    res_load    = 1'b1;
`ifdef THEREMIN_PERIOD_METER_IIR_EN
                    y_d      = y_init_q ? y_next : p_ext;
                    y_init_d = 1'b1;
                    res_data = CNT_W'(y_d >> AVG_LOG2);
`else
                    if (k_q == K_LAST) begin
                        res_data = CNT_W'(acc_sum >> AVG_LOG2);
                        acc_d    = '0;
                        k_d      = '0;
                    end else begin
                        res_load = 1'b0;
                        acc_d    = acc_sum;
                        k_d      = k_q + 5'd1;
                    end
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        if (res_load) begin
            data_d  = res_data;
            valid_d = 1'b1;
            if (valid_q && !period_ready) overrun_d = 1'b1;
        end else if (valid_q && period_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q     <= StIdle;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            edge_q      <= 1'b0;
            cnt_q       <= '0;
            no_signal_q <= 1'b1;
            valid_q     <= 1'b0;
            data_q      <= '0;
            overrun_q   <= 1'b0;
`ifdef THEREMIN_PERIOD_METER_IIR_EN
            y_q         <= '0;
            y_init_q    <= 1'b0;
`else
            acc_q       <= '0;
            k_q         <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= osc_in;
            sync2_q     <= sync1_q;
            edge_q      <= sync2_q;
            cnt_q       <= cnt_d;
            no_signal_q <= no_signal_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            overrun_q   <= overrun_d;
`ifdef THEREMIN_PERIOD_METER_IIR_EN
            y_q         <= y_d;
            y_init_q    <= y_init_d;
`else
            acc_q       <= acc_d;
            k_q         <= k_d;
`endif
        end
    end

    assign period_data  = data_q;
    assign period_valid = valid_q;
    assign no_signal    = no_signal_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_theremin_period_meter.sv
// Bench for theremin_period_meter: directed square waves against a rise-time-based model.
`timescale 1ns/1ps
module tb_theremin_period_meter;
    localparam int unsigned CNT_W      = 12;
    localparam int unsigned AVG_LOG2   = 2;
    localparam int unsigned MIN_PERIOD = 16;
    localparam int          TIMEOUT    = 4095;
    localparam int          NN         = 1 << AVG_LOG2;

    logic             clk_clk      = 1'b0;
    logic             reset_reset  = 1'b1;
    logic             osc_in       = 1'b0;
    logic             period_ready = 1'b1;
    logic [CNT_W-1:0] period_data;
    logic             period_valid, no_signal, overrun;

    always #5 clk_clk = ~clk_clk;

    theremin_period_meter #(
        .CNT_W     (CNT_W),
        .AVG_LOG2  (AVG_LOG2),
        .MIN_PERIOD(MIN_PERIOD),
        .TIMEOUT   (12'hFFF)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .osc_in      (osc_in),
        .period_data (period_data),
        .period_valid(period_valid),
        .period_ready(period_ready),
        .no_signal   (no_signal),
        .overrun     (overrun)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: tracks rise times (seen 2 cycles late through the synchroniser) and applies the
    // period rules with plain integer arithmetic.
    bit     m_pipe[$];
    bit     m_prev;
    bit     m_armed;
    int     m_since;
    int     m_periods[$];
    longint m_y;
    bit     m_yinit;
    int     m_data;
    bit     m_valid, m_nosig, m_ovr;

    always @(posedge clk_clk) begin
        bit r, new_res;
        int res, d, q;
        if (reset_reset) begin
            m_pipe = '{0, 0};
            m_prev = 0; m_armed = 0; m_since = 0; m_periods.delete();
            m_y = 0; m_yinit = 0;
            m_data = 0; m_valid = 0; m_nosig = 1; m_ovr = 0;
        end else begin
            r = m_pipe.pop_front();
            m_pipe.push_back(osc_in && !m_prev);
            m_prev  = osc_in;
            new_res = 0;
            res     = 0;
            if (m_since < 1000000) m_since++;
            if (m_armed && m_since == TIMEOUT + 1) begin
                m_armed = 0; m_nosig = 1; m_periods.delete(); m_y = 0; m_yinit = 0;
            end else if (r && !m_armed) begin
                m_armed = 1; m_since = 0; m_periods.delete(); m_yinit = 0;
            end else if (r && m_since >= MIN_PERIOD) begin
                m_nosig = 0;
`ifdef THEREMIN_PERIOD_METER_IIR_EN
                if (!m_yinit) m_y = m_since * NN;
                else begin
                    d = m_since * NN - int'(m_y);
                    q = (d >= 0) ? d / NN : -((-d + NN - 1) / NN);
                    m_y = m_y + q;
                end
                m_yinit = 1;
                res     = int'(m_y / NN);
                new_res = 1;
`else
                m_periods.push_back(m_since);
                if (m_periods.size() == NN) begin
                    res = 0;
                    foreach (m_periods[i]) res += m_periods[i];
                    res     = res / NN;
                    new_res = 1;
                    m_periods.delete();
                end
`endif
                m_since = 0;
            end
            if (new_res) begin
                if (m_valid && !period_ready) m_ovr = 1;
                m_data  = res;
                m_valid = 1;
            end else if (m_valid && period_ready) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk_clk) begin
        check("period_valid", 32'(period_valid), 32'(m_valid));
        check("period_data", 32'(period_data), 32'(m_data));
        check("no_signal", 32'(no_signal), 32'(m_nosig));
        check("overrun", 32'(overrun), 32'(m_ovr));
    end

    // Transfers and valid-high cycles, for the hand-computed expectations
    int got[$];
    int vcnt;
    always @(negedge clk_clk) begin
        if (period_valid) vcnt++;
        if (period_valid && period_ready) got.push_back(int'(period_data));
    end

    function automatic int qval(input int i);
        return (got.size() > i) ? got[i] : -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_clk);
            #2;
        end
    endtask

    task automatic do_reset();
        reset_reset = 1'b1;
        osc_in      = 1'b0;
        tick(3);
        reset_reset = 1'b0;
        tick(30);
        got.delete();
        vcnt = 0;
    endtask

    task automatic one_period(input int p, input bit glitch);
        osc_in = 1'b1;
        if (glitch) begin
            tick(3);
            osc_in = 1'b0;
            tick(5);
            osc_in = 1'b1;
            tick(p / 2 - 8);
        end else begin
            tick(p / 2);
        end
        osc_in = 1'b0;
        tick(p - p / 2);
    endtask

    task automatic close_rise();
        osc_in = 1'b1;
        tick(20);
        osc_in = 1'b0;
        tick(40);
    endtask

    initial begin
        do_reset();
        check("reset period_valid", 32'(period_valid), 32'd0);
        check("reset period_data", 32'(period_data), 32'd0);
        check("reset no_signal", 32'(no_signal), 32'd1);
        check("reset overrun", 32'(overrun), 32'd0);

`ifndef THEREMIN_PERIOD_METER_IIR_EN
        // Steady 1000-cycle wave
        one_period(1000, 0);
        check("t1 no_signal before 2nd edge", 32'(no_signal), 32'd1);
        repeat (3) one_period(1000, 0);
        close_rise();
        check("t1 no_signal after", 32'(no_signal), 32'd0);
        check("t1 results", got.size(), 1);
        check("t1 data", qval(0), 1000);
        check("t1 valid cycles", vcnt, 1);

        // Alternating periods, then truncation
        do_reset();
        one_period(998, 0); one_period(1002, 0); one_period(998, 0); one_period(1002, 0);
        one_period(1001, 0); one_period(1001, 0); one_period(1001, 0); one_period(1002, 0);
        close_rise();
        check("t2 results", got.size(), 2);
        check("t2 avg alt", qval(0), 1000);
        check("t2 avg trunc", qval(1), 1001);

        // Short dropout right after a rising edge is rejected
        do_reset();
        one_period(1000, 0); one_period(1000, 1); one_period(1000, 0); one_period(1000, 0);
        close_rise();
        check("t3 results", got.size(), 1);
        check("t3 data", qval(0), 1000);
        check("t3 valid cycles", vcnt, 1);

        // Consumer stalled across two results
        do_reset();
        period_ready = 1'b0;
        repeat (4) one_period(800, 0);
        repeat (4) one_period(600, 0);
        close_rise();
        check("t4 valid held", 32'(period_valid), 32'd1);
        check("t4 data latest", 32'(period_data), 32'd600);
        check("t4 overrun", 32'(overrun), 32'd1);
        period_ready = 1'b1;
        tick(1);
        check("t4 valid dropped", 32'(period_valid), 32'd0);
        check("t4 transfer", qval(0), 600);
        check("t4 overrun sticky", 32'(overrun), 32'd1);

        // Signal loss after two periods, then restart
        do_reset();
        one_period(500, 0); one_period(500, 0);
        close_rise();
        tick(TIMEOUT + 100);
        check("t5 no_signal", 32'(no_signal), 32'd1);
        check("t5 no partial result", got.size(), 0);
        repeat (4) one_period(500, 0);
        close_rise();
        check("t5 results", got.size(), 1);
        check("t5 data", qval(0), 500);
        check("t5 no_signal restored", 32'(no_signal), 32'd0);
`else
        // Exponential smoothing
        one_period(1000, 0); one_period(2000, 0);
        close_rise();
        check("t6 results", got.size(), 2);
        check("t6 first", qval(0), 1000);
        check("t6 second", qval(1), 1250);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
